// File: rtl/incubator_power_scheduler.sv
// Round-robin time-sharing of one actuator supply across incubator zones.
// Define SCHED_PREEMPT_EN to force a release once a grant reaches MAX_ON.
module incubator_power_scheduler #(
    parameter int N_ZONES = 4,
    parameter int MIN_ON  = 16,
    parameter int MAX_ON  = 64,
    parameter int GAP     = 4,
    localparam int ID_W   = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [N_ZONES-1:0] heat_req,
    input  logic [N_ZONES-1:0] cool_req,
    output logic [N_ZONES-1:0] heat_en,
    output logic [N_ZONES-1:0] cool_en,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id
);
    localparam int CNT_MAX = (MAX_ON > GAP) ? MAX_ON : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_gzone;
    logic               r_gmode;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_ZONES-1:0] r_heat_en;
    logic [N_ZONES-1:0] r_cool_en;

    logic [N_ZONES-1:0] w_elig;
    logic               w_found;
    logic [ID_W-1:0]    w_win;
    logic               w_win_heat;
    logic [N_ZONES-1:0] w_onehot;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_req;
    logic               w_min_done;
    logic               w_release;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_elig = heat_req | cool_req;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin : arb
        int j;
        w_found = 1'b0;
        w_win   = '0;
        j       = 0;
        for (int k = N_ZONES - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= N_ZONES) begin
                j = j - N_ZONES;
            end
            if (w_elig[j]) begin
                w_found = 1'b1;
                w_win   = ID_W'(j);
            end
        end
    end

    assign w_win_heat = heat_req[w_win];
    assign w_onehot   = {{(N_ZONES-1){1'b0}}, 1'b1} << w_win;
    assign w_ptr_nxt  = (w_win == ID_W'(N_ZONES - 1)) ? '0 : w_win + 1'b1;

    assign w_req      = r_gmode ? heat_req[r_gzone] : cool_req[r_gzone];
    assign w_min_done = (r_cnt >= CNT_W'(MIN_ON));

`ifdef SCHED_PREEMPT_EN
    assign w_release = (w_min_done && !w_req) || (r_cnt == CNT_W'(MAX_ON));
    assign w_cnt_inc = r_cnt + 1'b1;
`else
    assign w_release = w_min_done && !w_req;
    assign w_cnt_inc = w_min_done ? r_cnt : r_cnt + 1'b1;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gzone   <= '0;
            r_gmode   <= 1'b0;
            r_cnt     <= '0;
            r_heat_en <= '0;
            r_cool_en <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state   <= S_ON;
                        r_gzone   <= w_win;
                        r_gmode   <= w_win_heat;
                        r_ptr     <= w_ptr_nxt;
                        r_cnt     <= CNT_W'(1);
                        r_heat_en <= w_win_heat ? w_onehot : '0;
                        r_cool_en <= w_win_heat ? '0 : w_onehot;
                    end
                end
                S_ON: begin
                    if (w_release) begin
                        r_state   <= S_GAP;
                        r_cnt     <= CNT_W'(1);
                        r_heat_en <= '0;
                        r_cool_en <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_GAP: begin
                    if (r_cnt == CNT_W'(GAP)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_heat_en <= '0;
                    r_cool_en <= '0;
                end
            endcase
        end
    end

    assign heat_en  = r_heat_en;
    assign cool_en  = r_cool_en;
    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_gzone;

endmodule
